light_display_driver: RTL and testbench
=======================================

LIGHT_DISPLAY_DRIVER -- requirements
Module: light_display_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles each digit is held active during multiplexing; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 state  input  2  light phase from the traffic controller: 00 red, 01 green, 10 yellow, 11 invalid.
REQ-005 blink  input  1  green-flash phase from the controller; 1 means green is in its dark half.
REQ-006 countdown  input  8  remaining seconds, unsigned binary.
REQ-007 led_red, led_green, led_yellow  output  1 each  lamp drives, active-high.
REQ-008 seg  output  7  segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-009 an  output  2  digit enable, one-hot, active-high; an[1] is tens, an[0] is ones.
REQ-010 fault  output  1  sticky invalid-state flag.

Function
REQ-011 Inputs shall be captured into registers every clk cycle; all outputs shall be registered and derived from captured values, giving 2-cycle latency from an input change to the output change.
REQ-012 Lamp drives: led_red = captured state 00; led_yellow = captured state 10; led_green = captured state 01 AND NOT blink.
REQ-013 A 16-bit scan counter shall count 0..SCAN_DIV-1 and wrap; on wrap, digit select shall toggle, so an alternates 10 → 01 → 10, each held SCAN_DIV cycles.
REQ-014 Displayed value shall be min(countdown, 99); tens = value/10, ones = value%10.
REQ-015 seg shall show the digit selected by an, using standard 0-9 patterns (0 = 0111111, 9 = 1101111).
REQ-016 On any captured state 11: all lamps off, and both digits show dash, seg = 1000000.
REQ-017 fault shall set when captured state is 11 on two consecutive cycles.
REQ-018 fault shall remain set until rst_n is asserted; a single-cycle 11 glitch shall not set it.
REQ-019 An input change coinciding with a digit toggle shall be displayed on the new digit with the REQ-011 latency; no mixed-sample frame is allowed beyond one cycle.
REQ-020 Counter and digit select shall run freely, independent of state changes.

Reset
REQ-021 While rst_n = 0, all outputs shall be 0; capture registers, scan counter, digit select (tens) and fault shall clear.
REQ-022 Assertion mid-scan shall take effect immediately.
REQ-023 After deassertion, the first an = 10 shall appear on the first clk edge; scan shall restart from count 0.

Configuration
REQ-024 Macro DISP_LEADING_ZERO_BLANK_EN.
REQ-025 When DISP_LEADING_ZERO_BLANK_EN is defined, the tens digit shall show seg = 0000000 whenever displayed value < 10, with an still asserted.
REQ-026 When DISP_LEADING_ZERO_BLANK_EN is undefined, the tens digit shall show 0 (seg = 0111111) whenever displayed value < 10.
REQ-027 The dash display (REQ-016) shall be unaffected by DISP_LEADING_ZERO_BLANK_EN.

Structure
REQ-028 Package light_disp_pkg shall hold the state encodings (RED, GREEN, YELLOW, INVALID), the digit segment constants SEG_0..SEG_9, SEG_DASH and SEG_BLANK, and the SCAN_DIV default.
REQ-029 The combinational 4-bit to 7-segment decode shall be a sub-module seg7_encoder, instantiated once on the muxed digit.

Verification (SCAN_DIV = 4)
REQ-030 Reset release, state = 00, countdown = 9 → after 2 cycles: led_red = 1; tens digit shows 0 (blank if macro defined); ones digit shows 1101111; an toggles every 4 cycles.
REQ-031 state = 01, countdown = 7, blink toggling each cycle → led_green follows NOT blink with 2-cycle lag; red and yellow stay 0.
REQ-032 countdown = 150 → display shows 99 (seg 1101111 on both digits).
REQ-033 state = 11 for exactly 1 cycle → dashes and lamps off for 1 cycle; fault stays 0.
REQ-034 state = 11 for 3 cycles, then state = 10 → fault = 1 and stays 1; led_yellow = 1 after recovery.
REQ-035 rst_n pulsed low mid-scan with fault = 1 → fault, an, seg, lamps = 0 asynchronously; scan restarts on tens.

Source files
------------

// File: rtl/light_disp_pkg.sv
// Shared encodings for the traffic light display driver: light phases,
// seven-segment patterns {g,f,e,d,c,b,a} and the default scan divider.
package light_disp_pkg;

  typedef enum logic [1:0] {
    RED     = 2'b00,
    GREEN   = 2'b01,
    YELLOW  = 2'b10,
    INVALID = 2'b11
  } light_state_t;

  localparam int SCAN_DIV_DEFAULT = 50000;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/light_display_driver_seg7_encoder.sv
// Combinational BCD digit to seven-segment pattern decode.
// Codes above 9 never occur in this design and decode to blank.
module seg7_encoder
  import light_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/light_display_driver.sv
// Lamp and two-digit multiplexed countdown driver for the traffic controller.
// Define DISP_LEADING_ZERO_BLANK_EN to blank the tens digit for values below 10.
module light_display_driver
  import light_disp_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state,
  input  logic       blink,
  input  logic [7:0] countdown,
  output logic       led_red,
  output logic       led_green,
  output logic       led_yellow,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       fault
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  light_state_t cap_state;
  logic         cap_blink;
  logic [7:0]   cap_count;
  logic         inv_d;
  logic [15:0]  scan_cnt;
  logic         sel_tens;

  logic [6:0]   val;
  logic [3:0]   tens;
  logic [3:0]   ones;
  logic [3:0]   digit;
  logic [6:0]   enc_seg;
  logic [6:0]   seg_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state <= RED;
      cap_blink <= 1'b0;
      cap_count <= 8'd0;
      inv_d     <= 1'b0;
    end else begin
      cap_state <= light_state_t'(state);
      cap_blink <= blink;
      cap_count <= countdown;
      inv_d     <= (cap_state == INVALID);
    end
  end

  // Free-running scan; digit select flips on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= 16'd0;
      sel_tens <= 1'b1;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= 16'd0;
      sel_tens <= ~sel_tens;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  always_comb begin
    val   = (cap_count > 8'd99) ? 7'd99 : cap_count[6:0];
    tens  = 4'(val / 7'd10);
    ones  = 4'(val % 7'd10);
    digit = sel_tens ? tens : ones;
  end

  seg7_encoder u_seg7_encoder (
    .digit (digit),
    .seg   (enc_seg)
  );

  always_comb begin
    seg_next = enc_seg;
    if (cap_state == INVALID) begin
      seg_next = SEG_DASH;
    end
`ifdef DISP_LEADING_ZERO_BLANK_EN
    else if (sel_tens && (tens == 4'd0)) begin
      seg_next = SEG_BLANK;
    end
`else
    else begin
      seg_next = enc_seg;
    end
`endif
  end

  // an and seg come from the same sel_tens/capture sample, so a frame never mixes digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_red    <= 1'b0;
      led_green  <= 1'b0;
      led_yellow <= 1'b0;
      seg        <= SEG_BLANK;
      an         <= 2'b00;
      fault      <= 1'b0;
    end else begin
      led_red    <= (cap_state == RED);
      led_green  <= (cap_state == GREEN) && !cap_blink;
      led_yellow <= (cap_state == YELLOW);
      seg        <= seg_next;
      an         <= sel_tens ? 2'b10 : 2'b01;
      fault      <= fault || ((cap_state == INVALID) && inv_d);
    end
  end

endmodule

// File: tb/tb_light_display_driver.sv
// Directed self-checking bench for light_display_driver with SCAN_DIV = 4.
module tb_light_display_driver;
  import light_disp_pkg::*;

  localparam int SD = 4;
`ifdef DISP_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TZ = SEG_BLANK;
`else
  localparam logic [6:0] TZ = SEG_0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] state;
  logic       blink;
  logic [7:0] countdown;
  logic       led_red, led_green, led_yellow;
  logic [6:0] seg;
  logic [1:0] an;
  logic       fault;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  logic pb;

  light_display_driver #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .blink      (blink),
    .countdown  (countdown),
    .led_red    (led_red),
    .led_green  (led_green),
    .led_yellow (led_yellow),
    .seg        (seg),
    .an         (an),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Digit select model: tens for edges 1..SD after reset release, then alternating.
  function automatic logic [1:0] exp_an();
    return ((((cyc - 1) / SD) % 2) == 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic sample_check(input string tag, input logic [6:0] t, input logic [6:0] o);
    logic [1:0] ea;
    ea = exp_an();
    chk({tag, " an"}, 8'(an), 8'(ea));
    chk({tag, " seg"}, 8'(seg), 8'((ea == 2'b10) ? t : o));
  endtask

  task automatic check_scan(input string tag, input logic [6:0] t, input logic [6:0] o, input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      sample_check(tag, t, o);
    end
  endtask

  task automatic check_lamps(input string tag, input logic r, input logic g, input logic y);
    chk({tag, " red"}, 8'(led_red), 8'(r));
    chk({tag, " green"}, 8'(led_green), 8'(g));
    chk({tag, " yellow"}, 8'(led_yellow), 8'(y));
  endtask

  logic [7:0] bnd_cd [6]  = '{8'd150, 8'd99, 8'd100, 8'd10, 8'd0, 8'd255};
  logic [6:0] bnd_t  [6]  = '{SEG_9, SEG_9, SEG_9, SEG_1, TZ, SEG_9};
  logic [6:0] bnd_o  [6]  = '{SEG_9, SEG_9, SEG_9, SEG_0, SEG_0, SEG_9};

  initial begin
    rst_n = 1'b0; state = 2'b00; blink = 1'b0; countdown = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    check_lamps("in reset", 1'b0, 1'b0, 1'b0);
    chk("in reset an", 8'(an), 8'd0);
    chk("in reset seg", 8'(seg), 8'd0);
    chk("in reset fault", 8'(fault), 8'd0);

    // Red, countdown 9
    rst_n = 1'b1; cyc = 0;
    tick(1);
    chk("first an", 8'(an), 8'(2'b10));
    tick(1);
    check_lamps("red cd9", 1'b1, 1'b0, 1'b0);
    sample_check("cd9", TZ, SEG_9);
    check_scan("cd9", TZ, SEG_9, 8);

    // Green with blink toggling each cycle
    state = 2'b01; countdown = 8'd7; blink = 1'b0;
    tick(2);
    check_lamps("green steady", 1'b0, 1'b1, 1'b0);
    pb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      blink = ((i % 2) == 1);
      tick(1);
      check_lamps("green blink", 1'b0, !pb, 1'b0);
      sample_check("cd7", TZ, SEG_7);
      pb = blink;
    end
    blink = 1'b0;

    // Clamp and digit boundaries
    state = 2'b00;
    for (int k = 0; k < 6; k++) begin
      countdown = bnd_cd[k];
      tick(2);
      check_scan("bound", bnd_t[k], bnd_o[k], 4);
    end

    // Single-cycle invalid glitch (countdown still 255 -> 99)
    state = 2'b11;
    tick(1);
    state = 2'b00;
    tick(1);
    check_lamps("glitch", 1'b0, 1'b0, 1'b0);
    sample_check("glitch dash", SEG_DASH, SEG_DASH);
    chk("glitch fault", 8'(fault), 8'd0);
    tick(1);
    check_lamps("after glitch", 1'b1, 1'b0, 1'b0);
    sample_check("after glitch", SEG_9, SEG_9);
    chk("after glitch fault", 8'(fault), 8'd0);
    tick(1);
    chk("after glitch fault2", 8'(fault), 8'd0);

    // Sustained invalid, then yellow
    state = 2'b11;
    tick(2);
    check_lamps("invalid", 1'b0, 1'b0, 1'b0);
    sample_check("invalid dash", SEG_DASH, SEG_DASH);
    chk("invalid fault early", 8'(fault), 8'd0);
    tick(1);
    chk("invalid fault set", 8'(fault), 8'd1);
    sample_check("invalid dash2", SEG_DASH, SEG_DASH);
    state = 2'b10;
    tick(2);
    check_lamps("yellow recover", 1'b0, 1'b0, 1'b1);
    chk("fault sticky", 8'(fault), 8'd1);
    check_scan("yellow", SEG_9, SEG_9, 5);
    chk("fault sticky2", 8'(fault), 8'd1);

    // Asynchronous reset mid-scan
    rst_n = 1'b0;
    #1;
    check_lamps("async rst", 1'b0, 1'b0, 1'b0);
    chk("async rst an", 8'(an), 8'd0);
    chk("async rst seg", 8'(seg), 8'd0);
    chk("async rst fault", 8'(fault), 8'd0);
    @(posedge clk);
    #1;
    chk("held rst an", 8'(an), 8'd0);
    countdown = 8'd42;
    rst_n = 1'b1; cyc = 0;
    tick(1);
    chk("restart an", 8'(an), 8'(2'b10));
    tick(1);
    check_lamps("restart", 1'b0, 1'b0, 1'b1);
    chk("restart fault", 8'(fault), 8'd0);
    sample_check("cd42", SEG_4, SEG_2);
    check_scan("cd42", SEG_4, SEG_2, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
